seq_gen: RTL
============

# seq_gen

Serial pattern transmitter: captures a parallel word and drives it MSB-first, one bit per clock, onto a single-bit serial line, optionally repeating the frame with a one-cycle idle gap between repetitions. It is the driving end of the team's serial bit-pattern path, supplying the `x` stream consumed by the sequence detectors and their benches. A start/busy/done handshake lets a controller or bench launch frames without tracking timing.

## Interface

- `WIDTH`, default 8: maximum frame length in bits; width of `data`.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; forces reset state immediately, independent of `clk`.
- `start` input, 1 bit: frame request; sampled on the rising edge, honoured only in IDLE.
- `data` input, `WIDTH` bits: pattern; bits `[len-1:0]` are sent, bit `len-1` first.
- `len` input, 4 bits: bits per frame; 0 means the request is ignored; values above `WIDTH` are clamped to `WIDTH`.
- `reps` input, 4 bits: extra repetitions; the frame is sent `reps+1` times.
- `x` output, 1 bit: serial data, registered; idle level 1.
- `valid` output, 1 bit: high exactly in cycles where `x` carries a frame bit.
- `busy` output, 1 bit: high from the cycle after start acceptance through the last frame bit.
- `done` output, 1 bit: one-cycle pulse in the cycle after the final bit of the final repetition.

## Operation

- States: IDLE, SEND, GAP, DONE.
- IDLE → SEND when `start`=1 and `len`≠0.
  - On that edge, capture `data`, the clamped `len` and `reps` into internal registers.
  - Load the bit index with `len-1` and the repetition counter with `reps`.
- IDLE with `start`=1 and `len`=0: remain in IDLE; no output change.
- SEND:
  - `x` = captured `data[index]`, `valid`=1, `busy`=1; index decrements each cycle.
  - When index=0 and rep counter≠0: go to GAP, decrement the rep counter, reload index with `len-1`.
  - When index=0 and rep counter=0: go to DONE.
- GAP: one cycle, `x`=1, `valid`=0, `busy`=1; then → SEND.
- DONE: one cycle, `done`=1, `busy`=0, `x`=1, `valid`=0; then → IDLE unconditionally.
- `start` is ignored in SEND, GAP and DONE; no queuing.
- Input changes to `data`/`len`/`reps` after capture have no effect on the frame in progress.
- Index and counters are sized for `WIDTH` and 4 bits respectively; no wrap-around occurs within legal operation.
- Reset values: state IDLE, `x`=1, `valid`=0, `busy`=0, `done`=0, internal registers 0.
- Reset asserted mid-frame aborts immediately; no `done` pulse is produced for an aborted frame.

## Timing

- Edge E samples `start`=1 in IDLE. The first bit appears on `x`, with `valid` and `busy`, in the cycle after E.
- Frame bits occupy `len` consecutive cycles.
- Total busy cycles: `(reps+1)*len + reps`.
- `done` is high for exactly one cycle, immediately after the last busy cycle.
- Earliest next accepted start: sampled on the edge ending the cycle after `done`, i.e. back-to-back frames are separated by at least 2 non-valid cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** hold `reset`=1 for 15 ns with `clk` toggling and `start`=1 → `x`=1, `valid`=`busy`=`done`=0 throughout. Deassert `reset` → nothing happens until a start is sampled.
- **Single frame:** `data`=8'hA5, `len`=8, `reps`=0, one-cycle `start` → `x` = 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles. `done`=1 in cycle 9 after acceptance; then IDLE with `x`=1.
- **Repeats:** `data`=8'h05, `len`=3, `reps`=2 → `x` = 101, gap(1, valid=0), 101, gap, 101. `busy` high 11 cycles; `done` in cycle 12.
- **Four-zero pattern with detector loopback:** `data`=0, `len`=4, `reps`=0 → `x`=0,0,0,0 valid. The downstream detector flags on the fourth zero.
- **Ignored requests:**
  - `start` pulsed in mid-frame, with `data` changed the same cycle → no effect on the frame or its timing.
  - `start` with `len`=0 → stays IDLE, `busy` stays 0.
  - `len`=12 → clamped; exactly 8 bits are sent.
- **Async reset mid-frame:** assert `reset` between clock edges during bit 3 of an 8-bit frame → `x`=1, `valid`=`busy`=0 before the next edge; no `done` pulse. After release, a new start sends a full, correct frame.

Source files
------------

// File: rtl/seq_gen_if.sv
// Handshake and pattern bundle between a frame controller (master) and seq_gen (slave).
// The serial stream x with valid/busy/done status flows back to the controller.
interface seq_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [3:0]       len;
  logic [3:0]       reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, data, len, reps,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, data, len, reps,
    output x, valid, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a captured word out MSB-first on x, optionally
// repeating the frame with a one-cycle idle gap, and pulses done after the last bit.
module seq_gen #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  seq_gen_if.slave bus
);

  localparam int         IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] LEN_MAX = (WIDTH > 15) ? 4'd15 : 4'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       len_q, len_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       rep_q, rep_d;

  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       len_clamp_s;

  assign len_clamp_s = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

  // State and frame context registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= {WIDTH{1'b0}};
      len_q   <= 4'd0;
      idx_q   <= {IW{1'b0}};
      rep_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state and frame context update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != 4'd0)) begin
          state_d = S_SEND;
          data_d  = bus.data;
          len_d   = len_clamp_s;
          idx_d   = IW'(len_clamp_s - 4'd1);
          rep_d   = bus.reps;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (idx_q == {IW{1'b0}}) begin
          if (rep_q != 4'd0) begin
            state_d = S_GAP;
            rep_d   = rep_q - 4'd1;
            idx_d   = IW'(len_q - 4'd1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q - IW'(1'b1);
        end
      end
      S_GAP:   state_d = S_SEND;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    x_d     = 1'b1;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_SEND: begin
        x_d     = data_d[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: x_d    = 1'b1;
    endcase
  end

  // Output registers; the line idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
